// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential non-restoring divider
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIX
    } state_t;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// div_step: one combinational non-restoring divide iteration on {A,Q} against M
module div_step
    import div_pkg::*;
#(
    parameter int W = DIV_WIDTH
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] q,
    input  logic [W:0]   m,
    output logic [W:0]   a_next,
    output logic [W-1:0] q_next
);

    logic [W:0] a_sh;

    // shift {A,Q} left, add or subtract M on the old sign of A, new quotient bit is the inverted sign
    always_comb begin
        a_sh   = {a[W-1:0], q[W-1]};
        a_next = a[W] ? a_sh + m : a_sh - m;
        q_next = {q[W-2:0], ~a_next[W]};
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle signed divider sequencer producing {remainder, quotient}
// Optional feature: define DIV_ZERO_DETECT_EN to short-circuit zero divisors and raise div_zero.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_zero,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH:0]   a, a_step;
    logic [WIDTH-1:0] q, q_step, m, a_fix, quo, rem, mag_dd, mag_dv;
    logic [CW-1:0]    cnt;
    logic             sd, sq, accept, fix, zero_div, zero_take;

`ifdef DIV_ZERO_DETECT_EN
    assign zero_div = divisor == '0;
`else
    assign zero_div = 1'b0;
`endif

    assign accept    = state == IDLE && start;
    assign fix       = state == FIX;
    assign zero_take = accept && zero_div;
    assign busy      = state != IDLE;

    div_step #(.W(WIDTH)) u_step (
        .a      (a),
        .q      (q),
        .m      ({1'b0, m}),
        .a_next (a_step),
        .q_next (q_step)
    );

    // operand magnitudes, final restore and sign correction
    always_comb begin
        mag_dd = dividend[WIDTH-1] ? -dividend : dividend;
        mag_dv = divisor[WIDTH-1] ? -divisor : divisor;
        a_fix  = a[WIDTH] ? a[WIDTH-1:0] + m : a[WIDTH-1:0];
        quo    = sq ? -q : q;
        rem    = sd ? -a_fix : a_fix;
    end

    // state register
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= IDLE;
        else     state <= state_n;
    end

    // next state: zero divisors with detection enabled never leave IDLE
    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (start && !zero_div ? ITER : IDLE)
                : state == ITER ? (cnt == LAST ? FIX : ITER)
                : IDLE;
    end

    // operand capture on accept, one iteration per ITER cycle
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            a   <= '0;
            q   <= '0;
            m   <= '0;
            sd  <= 1'b0;
            sq  <= 1'b0;
            cnt <= '0;
        end else if (accept) begin
            a   <= '0;
            q   <= mag_dd;
            m   <= mag_dv;
            sd  <= dividend[WIDTH-1];
            sq  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            cnt <= '0;
        end else if (state == ITER) begin
            a   <= a_step;
            q   <= q_step;
            cnt <= cnt + 1'b1;
        end
    end

    // result register and single-cycle done pulse
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= fix || zero_take;
            if (fix)            result <= {rem, quo};
            else if (zero_take) result <= {dividend, {WIDTH{1'b1}}};
        end
    end

`ifdef DIV_ZERO_DETECT_EN
    // divide-by-zero flag, updated together with the result
    always_ff @(posedge clk or posedge clr) begin
        if (clr)                   div_zero <= 1'b0;
        else if (fix || zero_take) div_zero <= zero_take;
    end
`else
    assign div_zero = 1'b0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// tb_div_seq_ctrl: table-driven and scoreboarded checks of div_seq_ctrl
module tb_div_seq_ctrl;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           clr = 1'b1;
    logic           start = 1'b0;
    logic [W-1:0]   dividend = '0;
    logic [W-1:0]   divisor = '0;
    logic           busy, done, div_zero;
    logic [2*W-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]   dd;
        logic [W-1:0]   dv;
        logic [2*W-1:0] res;
    } vec_t;

    typedef struct {
        logic [2*W-1:0] res;
        bit             chk;
        int             lat;
        logic           dz;
    } exp_t;

    vec_t vecs[16];
    exp_t sb[$];

    div_seq_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .result   (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [W-1:0] dd, input logic [W-1:0] dv);
        logic signed [W-1:0] x, y, qq, rr;
        x  = dd;
        y  = dv;
        qq = x / y;
        rr = x % y;
        return {rr, qq};
    endfunction

    // drive a request (called at a negedge) and let the next posedge accept it
    task automatic issue(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic [2*W-1:0] res,
                         input bit chk, input int lat, input logic dz);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        sb.push_back('{res, chk, lat, dz});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // k counts negedges after the accepting edge; lat is edges after acceptance until done shows
    task automatic wait_done(input int poke);
        exp_t e;
        int k = 0;
        forever begin
            @(negedge clk);
            k++;
            if (k == poke) begin
                dividend = 32'h1234_5678;
                divisor  = 32'd3;
                start    = 1'b1;
            end
            if (k == poke + 1) start = 1'b0;
            if (k == 1) begin
                check("busy_after_accept", 64'(busy), 64'(sb[0].lat > 0));
                if (sb[0].lat > 0) check("done_low_after_accept", 64'(done), 64'd0);
            end
            if (done) begin
                e = sb.pop_front();
                check("latency", 64'(k - 1), 64'(e.lat));
                check("busy_low_with_done", 64'(busy), 64'd0);
                check("div_zero", 64'(div_zero), 64'(e.dz));
                if (e.chk) check("result", result, e.res);
                return;
            end
            if (k > 60) begin
                checks++;
                errors++;
                $display("FAIL done_timeout: no done after %0d cycles, expected at %0d", k, sb[0].lat);
                sb.delete(0);
                return;
            end
        end
    endtask

    task automatic run_op(input logic [W-1:0] dd, input logic [W-1:0] dv, input logic [2*W-1:0] res,
                          input bit chk, input int lat, input logic dz, input int poke);
        @(negedge clk);
        issue(dd, dv, res, chk, lat, dz);
        wait_done(poke);
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'd0);
    endtask

    initial begin
        int pulses;
        logic [W-1:0] rd, rv;

        vecs[0]  = '{32'd100,       32'd7,         {32'd2,         32'd14}};
        vecs[1]  = '{32'hFFFFFF9C,  32'd7,         {32'hFFFFFFFE,  32'hFFFFFFF2}};
        vecs[2]  = '{32'd100,       32'hFFFFFFF9,  {32'h00000002,  32'hFFFFFFF2}};
        vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE,  32'd14}};
        vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  {32'd0,         32'h80000000}};
        vecs[5]  = '{32'h7FFFFFFF,  32'd1,         {32'd0,         32'h7FFFFFFF}};
        vecs[6]  = '{32'h80000000,  32'd1,         {32'd0,         32'h80000000}};
        vecs[7]  = '{32'h80000000,  32'd2,         {32'd0,         32'hC0000000}};
        vecs[8]  = '{32'h7FFFFFFF,  32'h80000000,  {32'h7FFFFFFF,  32'd0}};
        vecs[9]  = '{32'h80000000,  32'h80000000,  {32'd0,         32'd1}};
        vecs[10] = '{32'd5,         32'd9,         {32'd5,         32'd0}};
        vecs[11] = '{32'd0,         32'd5,         {32'd0,         32'd0}};
        vecs[12] = '{32'd1000,      32'd3,         {32'd1,         32'd333}};
        vecs[13] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  {32'd0,         32'd1}};
        vecs[14] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  {32'd0,         32'd1}};
        vecs[15] = '{32'hFFFFFFF9,  32'd2,         {32'hFFFFFFFF,  32'hFFFFFFFD}};

        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_div_zero", 64'(div_zero), 64'd0);
        check("reset_result", result, 64'd0);
        clr = 1'b0;

        for (int i = 0; i < 16; i++)
            run_op(vecs[i].dd, vecs[i].dv, vecs[i].res, 1'b1, 33, 1'b0, -1);

        // start raised in the done cycle is accepted immediately
        @(negedge clk);
        issue(32'd500, 32'd7, {32'd3, 32'd71}, 1'b1, 33, 1'b0);
        wait_done(-1);
        issue(32'hFFFFFE0C, 32'd7, {32'hFFFFFFFD, 32'hFFFFFFB9}, 1'b1, 33, 1'b0);
        wait_done(-1);
        @(negedge clk);
        check("b2b_done_single_pulse", 64'(done), 64'd0);

        // start with other operands during iteration 5 is ignored
        run_op(32'd100, 32'd7, {32'd2, 32'd14}, 1'b1, 33, 1'b0, 6);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignored_start_no_extra_done", 64'(pulses), 64'd0);
        check("ignored_start_idle", 64'(busy), 64'd0);

`ifdef DIV_ZERO_DETECT_EN
        run_op(32'd55, 32'd0, {32'd55, 32'hFFFFFFFF}, 1'b1, 0, 1'b1, -1);
        check("div_zero_held", 64'(div_zero), 64'd1);
`else
        run_op(32'd55, 32'd0, 64'd0, 1'b0, 33, 1'b0, -1);
`endif

        // clear in the middle of the iterations
        @(negedge clk);
        issue(32'd77, 32'd5, 64'd0, 1'b0, 33, 1'b0);
        repeat (10) @(negedge clk);
        clr = 1'b1;
        #1;
        check("clr_busy", 64'(busy), 64'd0);
        check("clr_done", 64'(done), 64'd0);
        check("clr_result", result, 64'd0);
        check("clr_div_zero", 64'(div_zero), 64'd0);
        sb.delete(0);
        @(negedge clk);
        clr = 1'b0;
        run_op(32'd1000, 32'd3, {32'd1, 32'd333}, 1'b1, 33, 1'b0, -1);

        for (int i = 0; i < 10; i++) begin
            rd = $urandom;
            rv = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 50));
            if (i % 4 == 3) rv = -rv;
            if (rv == 0) rv = 32'd1;
            if (rd == 32'h80000000 && rv == 32'hFFFFFFFF) rv = 32'd3;
            run_op(rd, rv, model(rd, rv), 1'b1, 33, 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
